// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter among NUM_REQ byte producers, plus the baud tick divider.
// Accept-to-tx_valid is 1 cycle; tx_ready low stalls in HOLD indefinitely, with every req_ready held low.
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int TICK_DIV = 16,
  parameter int CNT_W    = 16,
  localparam int ID_W    = $clog2(NUM_REQ),
  localparam int DIV_W   = $clog2(TICK_DIV)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_bits,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_bits,
  input  logic                 tx_ready,
  output logic                 tick,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic [CNT_W-1:0]     sent_count
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               tx_valid_q, tx_valid_d;
  logic [7:0]         tx_bits_q, tx_bits_d;
  logic [CNT_W-1:0]   sent_count_q, sent_count_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [NUM_REQ-1:0] rdy;
  logic               found;
  logic [ID_W-1:0]    gnt;
  logic [ID_W:0]      sum;

  // Search starts at ptr and wraps; the extra sum bit holds ptr+k before folding.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[sum[ID_W-1:0]]) begin
        found = 1'b1;
        gnt   = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_id_d   = grant_id_q;
    tx_valid_d   = tx_valid_q;
    tx_bits_d    = tx_bits_q;
    sent_count_d = sent_count_q;
    rdy          = '0;
    div_d        = (div_q == DIV_W'(TICK_DIV-1)) ? '0 : div_q + DIV_W'(1);
    case (state_q)
      IDLE: begin
        if (found) begin
          rdy[gnt]   = 1'b1;
          tx_bits_d  = req_bits[gnt*8 +: 8];
          grant_id_d = gnt;
          ptr_d      = (gnt == ID_W'(NUM_REQ-1)) ? '0 : gnt + ID_W'(1);
          tx_valid_d = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (tx_ready) begin
          tx_valid_d   = 1'b0;
          sent_count_d = sent_count_q + CNT_W'(1);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      grant_id_q   <= '0;
      tx_valid_q   <= 1'b0;
      tx_bits_q    <= '0;
      sent_count_q <= '0;
      div_q        <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_id_q   <= grant_id_d;
      tx_valid_q   <= tx_valid_d;
      tx_bits_q    <= tx_bits_d;
      sent_count_q <= sent_count_d;
      div_q        <= div_d;
    end
  end

  // The divider register is stale while reset is low, so both strobes are gated.
  assign req_ready  = reset ? rdy : '0;
  assign tick       = reset && (div_q == DIV_W'(TICK_DIV-1));
  assign tx_valid   = tx_valid_q;
  assign tx_bits    = tx_bits_q;
  assign grant_id   = grant_id_q;
  assign busy       = tx_valid_q;
  assign sent_count = sent_count_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UARTTransmitter between NUM_REQ byte producers, e.g. the command encoder, debug echo and status reporter.
- Grants access round-robin.
- Captures the granted byte and presents it to the transmitter's valid/ready port.
- Generates the transmitter's `tick` baud-enable strobe from a free-running divider.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TICK_DIV, 16, clock cycles per `tick` pulse (>=2).
- CNT_W, 16, width of `sent_count`.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  NUM_REQ  per-requester byte-available flag.
- req_bits  in  NUM_REQ*8  requester i's byte at bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept strobe; transfer when req_valid[i] & req_ready[i].
- tx_valid  out  1  byte offered to UARTTransmitter io_valid.
- tx_bits  out  8  byte to UARTTransmitter io_bits.
- tx_ready  in  1  UARTTransmitter io_ready.
- tick  out  1  baud-enable strobe to UARTTransmitter tick.
- grant_id  out  clog2(NUM_REQ)  index of the requester whose byte is held or was last sent.
- busy  out  1  high while a captured byte has not yet been accepted by the transmitter.
- sent_count  out  CNT_W  number of bytes accepted by the transmitter, modulo 2^CNT_W.

Behaviour:
- **Reset** (reset==0 at a rising edge) forces:
  - state=IDLE, ptr=0, grant_id=0, tx_valid=0, tx_bits=0, busy=0, sent_count=0, tick divider=0.
  - tick=0 and req_ready=0 while reset is asserted.
- **Reset mid-frame:** a held byte is discarded. No req_ready is issued during reset.
- **Tick divider:**
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = (count==TICK_DIV-1), a single-cycle pulse.
  - First pulse is in the TICK_DIV-th cycle after reset release; period is exactly TICK_DIV thereafter.
  - Runs independently of the FSM.
- **FSM state IDLE:**
  - Combinational round-robin search over req_valid, starting at index ptr, ascending, wrapping at NUM_REQ.
  - The first set index g receives req_ready[g]=1; all other req_ready bits are 0.
  - If no req_valid is set, req_ready=0 and the state stays IDLE.
  - On transfer at the edge: tx_bits<=req_bits[g], grant_id<=g, ptr<=(g+1) mod NUM_REQ, tx_valid<=1, busy<=1, state<=HOLD.
- **FSM state HOLD:**
  - req_ready=0 for all requesters.
  - tx_valid and tx_bits are held stable until tx_valid & tx_ready.
  - At that edge: tx_valid<=0, busy<=0, sent_count<=sent_count+1 (wraps), state<=IDLE.
- **Throughput and latency:**
  - Minimum one idle cycle between consecutive transmitter handshakes.
  - Accept-to-tx_valid latency is 1 cycle.
  - With tx_ready already high, tx_valid is high for exactly 1 cycle.
- **Requester side:**
  - Requesters may drop or change req_valid/req_bits at any time.
  - Only a completed req_valid & req_ready transfer is captured.
  - A requester must not assume acceptance without req_ready.
- **Simultaneous requests:** all requesters valid with ptr=0 gives grant order 0,1,2,3,0,... No requester waits more than NUM_REQ-1 grants.
- **Single requester:** a sole requester held valid is served on every IDLE visit regardless of ptr.
- **tx_ready:**
  - tx_ready low in HOLD stalls indefinitely; no timeout.
  - tx_ready is ignored in IDLE.
- grant_id holds its value in IDLE until the next grant.

Test Plan:
- **Reset/tick:** hold reset=0 for 5 cycles, release. Expect tick=0 throughout reset, first tick in cycle 16 after release, then every 16 cycles; all outputs 0 at release.
- **Single byte:** req_valid=4'b0100 with req_bits[23:16]=8'h65, tx_ready=1. Expect:
  - req_ready=4'b0100 for 1 cycle.
  - Next cycle tx_valid=1, tx_bits=8'h65, grant_id=2.
  - Following cycle tx_valid=0, sent_count=1.
- **Round-robin fairness:** all four valid with distinct bytes 8'hA0..8'hA3, tx_ready=1. Expect tx_bits sequence A0,A1,A2,A3,A0 and grant_id 0,1,2,3,0.
- **Backpressure:** accept 8'h21 from requester 1, hold tx_ready=0 for 40 cycles. Expect:
  - tx_valid=1 and tx_bits=8'h21 stable, busy=1, req_ready=0 throughout.
  - tx_ready=1 completes the transfer in 1 cycle.
- **Reset mid-operation:** in HOLD with tx_ready=0, pulse reset=0 for 1 edge. Expect tx_valid=0, busy=0, ptr=0 next cycle and the byte not counted; a following request from requester 3 is served normally.
- **Counter wrap:** with CNT_W=4, send 17 bytes. Expect sent_count to read 1.
